// File: rtl/frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_writer_pkg
// Brief   : Shared state encoding and header field layout for the column
//           frame writer.
// Rev     : 1.0  initial release
// ============================================================================
package frame_writer_pkg;

  localparam int WORD_W       = 32;
  localparam int SYNC_W       = 16;
  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 16;
  localparam int HDR_IDX_MSB  = 4;
  localparam int HDR_IDX_LSB  = 0;
  localparam int IDX_W        = HDR_IDX_MSB - HDR_IDX_LSB + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DROP   = 3'd2,
    CHECK  = 3'd3,
    STROBE = 3'd4
  } fcw_state_e;

endpackage
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module  : frame_strobe_decoder
// Brief   : Registered index-to-one-hot decode; output is a single-cycle pulse
//           on the cycle after i_en.
// Rev     : 1.0  initial release
// ============================================================================
module frame_strobe_decoder
  import frame_writer_pkg::*;
#(
  parameter int NUM_OUT = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [NUM_OUT-1:0] o_strobe
);

  logic [NUM_OUT-1:0] r_strobe;
  logic [NUM_OUT-1:0] w_onehot;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_onehot[i] = (32'(i_idx) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= i_en ? w_onehot : '0;
    end
  end

  assign o_strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/frame_column_writer.sv
`default_nettype none
// ============================================================================
// Module  : frame_column_writer
// Brief   : Assembles header + NumRows data words into one column frame and
//           pulses the matching FrameStrobe bit. Define FRAME_WRITER_CRC_EN to
//           require a trailing XOR check word before the strobe.
// Rev     : 1.0  initial release
// ============================================================================
module frame_column_writer
  import frame_writer_pkg::*;
#(
  parameter int                MaxFramesPerCol = 20,
  parameter int                FrameBitsPerRow = 32,
  parameter int                NumRows         = 2,
  parameter logic [SYNC_W-1:0] SyncWord        = 16'hFAB0
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [WORD_W-1:0]                  s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err_hdr,
  output logic                               err_crc
);

  localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

  if (FrameBitsPerRow != WORD_W) begin : g_bad_row_width
    $error("FrameBitsPerRow must equal the 32-bit stream word width");
  end

  fcw_state_e                       r_state;
  logic [ROW_W-1:0]                 r_row;
  logic [IDX_W-1:0]                 r_idx;
  logic [FrameBitsPerRow*NumRows-1:0] r_frame_data;
  logic                             r_s_ready;
  logic                             r_busy;
  logic                             r_err_hdr;

  logic              w_xfer;
  logic              w_last_row;
  logic              w_sync_ok;
  logic              w_idx_ok;
  logic              w_to_strobe;
  logic [IDX_W-1:0]  w_hdr_idx;

  assign w_xfer     = s_valid && r_s_ready;
  assign w_last_row = (r_row == ROW_W'(NumRows - 1));
  assign w_hdr_idx  = s_data[HDR_IDX_MSB:HDR_IDX_LSB];
  assign w_sync_ok  = (s_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == SyncWord);
  assign w_idx_ok   = (32'(w_hdr_idx) < MaxFramesPerCol);

`ifdef FRAME_WRITER_CRC_EN
  logic [WORD_W-1:0] r_crc;
  logic              r_err_crc;

  assign w_to_strobe = w_xfer && (r_state == CHECK) && (s_data == r_crc);
  assign err_crc     = r_err_crc;
`else
  assign w_to_strobe = w_xfer && (r_state == LOAD) && w_last_row;
  assign err_crc     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_idx        <= '0;
      r_frame_data <= '0;
      r_s_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_err_hdr    <= 1'b0;
`ifdef FRAME_WRITER_CRC_EN
      r_crc        <= '0;
      r_err_crc    <= 1'b0;
`endif
    end else begin
      r_err_hdr <= 1'b0;
`ifdef FRAME_WRITER_CRC_EN
      r_err_crc <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // ready rises here on the first edge after reset release
          r_s_ready <= 1'b1;
          if (w_xfer) begin
            if (!w_sync_ok) begin
              r_err_hdr <= 1'b1;
            end else if (!w_idx_ok) begin
              r_err_hdr <= 1'b1;
              r_row     <= '0;
              r_busy    <= 1'b1;
              r_state   <= DROP;
            end else begin
              r_idx   <= w_hdr_idx;
              r_row   <= '0;
              r_busy  <= 1'b1;
              r_state <= LOAD;
`ifdef FRAME_WRITER_CRC_EN
              r_crc   <= s_data;
`endif
            end
          end
        end
        LOAD: begin
          if (w_xfer) begin
            for (int r = 0; r < NumRows; r++) begin
              if (r_row == ROW_W'(r)) begin
                r_frame_data[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
              end
            end
            r_row <= r_row + 1'b1;
`ifdef FRAME_WRITER_CRC_EN
            r_crc <= r_crc ^ s_data;
            if (w_last_row) begin
              r_row   <= '0;
              r_state <= CHECK;
            end
`else
            if (w_last_row) begin
              r_row     <= '0;
              r_s_ready <= 1'b0;
              r_state   <= STROBE;
            end
`endif
          end
        end
        DROP: begin
          if (w_xfer) begin
            r_row <= r_row + 1'b1;
            if (w_last_row) begin
              r_row   <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
`ifdef FRAME_WRITER_CRC_EN
        CHECK: begin
          if (w_xfer) begin
            if (s_data == r_crc) begin
              r_s_ready <= 1'b0;
              r_state   <= STROBE;
            end else begin
              r_err_crc <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
`endif
        STROBE: begin
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  frame_strobe_decoder #(
    .NUM_OUT (MaxFramesPerCol)
  ) u_strobe_dec (
    .clk      (CLK),
    .rst_n    (resetn),
    .i_en     (w_to_strobe),
    .i_idx    (r_idx),
    .o_strobe (FrameStrobe)
  );

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign err_hdr   = r_err_hdr;
  assign FrameData = r_frame_data;

endmodule
`default_nettype wire

// File: tb/tb_frame_column_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_column_writer
// Brief   : Scoreboard bench for frame_column_writer; honours FRAME_WRITER_CRC_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_frame_column_writer;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        err_hdr;
  logic        err_crc;

  frame_column_writer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err_hdr     (err_hdr),
    .err_crc     (err_crc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [19:0] strobe;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_strobe = 0, exp_strobe = 0;
  int          n_err_hdr = 0, exp_err_hdr = 0;
  int          n_err_crc = 0, exp_err_crc = 0;
  logic [63:0] model_fd = '0;
  bit          prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe pops one scoreboard entry.
  always @(negedge CLK) begin
    if (resetn) begin
      if (prev_strobe) begin
        check("busy_after_strobe", {63'd0, busy}, 64'd0);
        check("ready_after_strobe", {63'd0, s_ready}, 64'd1);
      end
      if (FrameStrobe != '0) begin
        n_strobe++;
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", {44'd0, FrameStrobe}, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("strobe", {44'd0, FrameStrobe}, {44'd0, mon_e.strobe});
          check("strobe_data", FrameData, mon_e.data);
          check("ready_in_strobe", {63'd0, s_ready}, 64'd0);
        end
      end
      if (err_hdr) n_err_hdr++;
      if (err_crc) n_err_crc++;
      prev_strobe = (FrameStrobe != '0);
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic xfer(input logic [31:0] w, input bit hold);
    int n;
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!s_ready) begin
      check("xfer_timeout", {63'd0, s_ready}, 64'd1);
      s_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0,
                            input logic [31:0] d1, input bit crc_good, input bit hold);
    logic [31:0] crc;
    bit          idx_ok;
    exp_t        e;
    crc    = hdr ^ d0 ^ d1;
    idx_ok = (hdr[4:0] < 5'd20);
    xfer(hdr, hold);
    if (hdr[31:16] != 16'hFAB0) begin
      exp_err_hdr++;
      return;
    end
    if (!idx_ok) begin
      exp_err_hdr++;
      xfer(d0, hold);
      xfer(d1, hold);
      return;
    end
    e.strobe = 20'd1 << hdr[4:0];
    e.data   = {d1, d0};
    xfer(d0, hold);
    model_fd[31:0] = d0;
`ifdef FRAME_WRITER_CRC_EN
    xfer(d1, hold);
    model_fd[63:32] = d1;
    if (crc_good) begin
      sb_q.push_back(e);
      exp_strobe++;
    end else begin
      exp_err_crc++;
    end
    xfer(crc_good ? crc : (crc ^ 32'h0000_0100), hold);
`else
    sb_q.push_back(e);
    exp_strobe++;
    xfer(d1, hold);
    model_fd[63:32] = d1;
`endif
  endtask

  task automatic checkpoint(input string tag);
    gap(4);
    check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    check({tag, "_strobes"}, 64'(n_strobe), 64'(exp_strobe));
    check({tag, "_err_hdr"}, 64'(n_err_hdr), 64'(exp_err_hdr));
    check({tag, "_err_crc"}, 64'(n_err_crc), 64'(exp_err_crc));
    check({tag, "_frame_data"}, FrameData, model_fd);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fd"}, FrameData, 64'd0);
    check({tag, "_strobe"}, {44'd0, FrameStrobe}, 64'd0);
    check({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_errs"}, {62'd0, err_hdr, err_crc}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    resetn = 1'b1;
    #1;
    check("ready_first_cycle", {63'd0, s_ready}, 64'd0);
    @(negedge CLK);
    check("ready_after_rst", {63'd0, s_ready}, 64'd1);

    // basic frame, idx 3
    send_frame(32'hFAB0_0003, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    checkpoint("basic");

    // bad sync, then top legal index
    send_frame(32'hFAB1_0000, 32'h0, 32'h0, 1'b1, 1'b0);
    checkpoint("badsync");
    send_frame(32'hFAB0_0013, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
    checkpoint("idx19");

    // out-of-range indices: words dropped, FrameData held
    send_frame(32'hFAB0_0014, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
    checkpoint("idx20");
    send_frame(32'hFAB0_001F, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b0);
    checkpoint("idx31");

    // reset mid-frame with gaps in s_valid
    xfer(32'hFAB0_0005, 1'b0);
    gap($urandom_range(0, 3));
    xfer(32'h7777_8888, 1'b0);
    for (int i = 0; i < 3; i++) gap($urandom_range(1, 3));
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_fd = '0;
    @(negedge CLK);
    resetn = 1'b1;
    #1;
    check("midrst_ready_first", {63'd0, s_ready}, 64'd0);
    @(negedge CLK);
    checkpoint("midrst");
    send_frame(32'hFAB0_0005, 32'h0BAD_F00D, 32'h0123_4567, 1'b1, 1'b0);
    checkpoint("after_rst");

    // back-to-back with s_valid held high
    send_frame(32'hFAB0_0000, 32'hAAAA_0000, 32'hBBBB_0000, 1'b1, 1'b1);
    send_frame(32'hFAB0_0001, 32'hAAAA_1111, 32'hBBBB_1111, 1'b1, 1'b1);
    s_valid = 1'b0;
    checkpoint("b2b");

`ifdef FRAME_WRITER_CRC_EN
    send_frame(32'hFAB0_0007, 32'h0F0F_0F0F, 32'hF00F_1234, 1'b1, 1'b0);
    checkpoint("crc_good");
    send_frame(32'hFAB0_0008, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b0);
    checkpoint("crc_bad");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
